ddr_cmd_responder: RTL

- Device-side DDR4 command responder: decodes the command pins driven by the controller, tracks per-bank state and open row for 16 banks, and enforces tRRD/tRCD/tRP.
- Produces the CL/CWL-delayed read/write data-enable windows and flags protocol violations.
- Sits on the device side of ddr_interface, opposite the controller's ACT/PRE/CAS schedulers.
- Serves as the DUT's memory-side checker and as the data-phase timing source for the memory model.

---
 rtl/ddr_cmd_responder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr_cmd_responder.sv
// Device-side DDR4 command responder: decodes controller commands, tracks 16 banks,
// enforces tRRD/tRCD/tRP, generates CL/CWL data-enable windows and flags violations.
module ddr_cmd_responder #(
  parameter int unsigned tRRD = 4,
  parameter int unsigned tRCD = 16,
  parameter int unsigned tRP  = 16,
  parameter int unsigned CL   = 16,
  parameter int unsigned CWL  = 12,
  parameter int unsigned BL   = 8
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  bg,
  input  logic [1:0]  ba,
  input  logic [14:0] addr,
  input  logic [3:0]  mon_bank,
  output logic [14:0] mon_row,
  output logic [15:0] bank_open,
  output logic        rd_data_en,
  output logic        wr_data_en,
  output logic        err_valid,
  output logic [2:0]  err_code
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } bank_state_e;

  localparam int unsigned HALF = BL / 2;
  localparam int unsigned RD_W = CL + HALF - 1;
  localparam int unsigned WR_W = CWL + HALF - 1;
  // Bit j of a window register drives the data enable j+1 cycles after the command.
  localparam logic [RD_W-1:0] RD_MASK = {{HALF{1'b1}}, {(CL-1){1'b0}}};
  localparam logic [WR_W-1:0] WR_MASK = {{HALF{1'b1}}, {(CWL-1){1'b0}}};
  localparam logic [4:0] RRD_MAX   = 5'(tRRD);
  localparam logic [4:0] RRD_LEGAL = 5'(tRRD - 1);
  localparam logic [4:0] RCD_DONE  = 5'(tRCD - 1);
  localparam logic [4:0] RP_DONE   = 5'(tRP - 1);

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  bank_state_e        r_state [16];
  logic [14:0]        r_row   [16];
  logic [4:0]         r_cnt   [16];
  logic [4:0]         r_rrd;
  logic [RD_W-1:0]    r_rd_sr;
  logic [WR_W-1:0]    r_wr_sr;
  logic               r_err_valid;
  logic [2:0]         r_err_code;

  logic [3:0]  w_bank;
  logic [2:0]  w_rcw;
  logic        w_is_act, w_is_pre, w_is_rd, w_is_wr, w_is_ref;
  logic [15:0] w_open, w_ready, w_idle, w_pre_hit;
  logic        w_err, w_act_ok, w_rd_ok, w_wr_ok;
  logic [2:0]  w_code;

  assign w_bank   = {bg, ba};
  assign w_rcw    = {ras_n, cas_n, we_n};
  assign w_is_act = !cs_n && !act_n;
  assign w_is_pre = !cs_n && act_n && (w_rcw == 3'b010);
  assign w_is_rd  = !cs_n && act_n && (w_rcw == 3'b101);
  assign w_is_wr  = !cs_n && act_n && (w_rcw == 3'b100);
  assign w_is_ref = !cs_n && act_n && (w_rcw == 3'b001);

  // Per-bank status; a bank finishing its tRCD/tRP count this edge counts as already there.
  always_comb begin
    w_open    = '0;
    w_ready   = '0;
    w_idle    = '0;
    w_pre_hit = '0;
    for (int i = 0; i < 16; i++) begin
      w_open[i]    = (r_state[i] == ST_ACTIVATING) || (r_state[i] == ST_ACTIVE);
      w_ready[i]   = (r_state[i] == ST_ACTIVE) ||
                     ((r_state[i] == ST_ACTIVATING) && (r_cnt[i] == RCD_DONE));
      w_idle[i]    = (r_state[i] == ST_IDLE) ||
                     ((r_state[i] == ST_PRECHARGING) && (r_cnt[i] == RP_DONE));
      w_pre_hit[i] = w_is_pre && (addr[10] || (w_bank == 4'(i)));
    end
  end

  // Command legality check and violation code selection.
  always_comb begin
    w_err    = 1'b0;
    w_code   = 3'd0;
    w_act_ok = 1'b0;
    w_rd_ok  = 1'b0;
    w_wr_ok  = 1'b0;
    if (w_is_act) begin
      if (!w_idle[w_bank]) begin
        w_err  = 1'b1;
        w_code = 3'd1;
      end else if (r_rrd < RRD_LEGAL) begin
        w_err  = 1'b1;
        w_code = 3'd2;
      end else begin
        w_act_ok = 1'b1;
      end
    end else if (w_is_rd || w_is_wr) begin
      if (!w_open[w_bank]) begin
        w_err  = 1'b1;
        w_code = 3'd3;
      end else if (!w_ready[w_bank]) begin
        w_err  = 1'b1;
        w_code = 3'd4;
      end else begin
        w_rd_ok = w_is_rd;
        w_wr_ok = w_is_wr;
      end
    end else if (w_is_ref) begin
      if (w_idle != 16'hFFFF) begin
        w_err  = 1'b1;
        w_code = 3'd5;
      end else begin
        w_err = 1'b0;
      end
    end else begin
      w_err = 1'b0;
    end
  end

  // Per-bank state machines, open rows and timing counters.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        r_state[i] <= ST_IDLE;
        r_row[i]   <= 15'd0;
        r_cnt[i]   <= 5'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        r_cnt[i] <= sat_inc(r_cnt[i]);
        case (r_state[i])
          ST_IDLE: begin
            if (w_act_ok && (w_bank == 4'(i))) begin
              r_state[i] <= ST_ACTIVATING;
              r_row[i]   <= addr;
              r_cnt[i]   <= 5'd0;
            end
          end
          ST_ACTIVATING: begin
            if (w_pre_hit[i]) begin
              r_state[i] <= ST_PRECHARGING;
              r_cnt[i]   <= 5'd0;
            end else if (r_cnt[i] == RCD_DONE) begin
              r_state[i] <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (w_pre_hit[i]) begin
              r_state[i] <= ST_PRECHARGING;
              r_cnt[i]   <= 5'd0;
            end
          end
          ST_PRECHARGING: begin
            if (w_act_ok && (w_bank == 4'(i))) begin
              r_state[i] <= ST_ACTIVATING;
              r_row[i]   <= addr;
              r_cnt[i]   <= 5'd0;
            end else if (r_cnt[i] == RP_DONE) begin
              r_state[i] <= ST_IDLE;
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  // tRRD counter, data-enable shift registers and the error report.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_rrd       <= RRD_MAX;
      r_rd_sr     <= '0;
      r_wr_sr     <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= 3'd0;
    end else begin
      if (w_act_ok) begin
        r_rrd <= 5'd0;
      end else if (r_rrd != RRD_MAX) begin
        r_rrd <= r_rrd + 5'd1;
      end else begin
        r_rrd <= r_rrd;
      end
      r_rd_sr     <= (r_rd_sr >> 1) | (w_rd_ok ? RD_MASK : '0);
      r_wr_sr     <= (r_wr_sr >> 1) | (w_wr_ok ? WR_MASK : '0);
      r_err_valid <= w_err;
      if (w_err) begin
        r_err_code <= w_code;
      end else begin
        r_err_code <= r_err_code;
      end
    end
  end

  assign bank_open  = w_open;
  assign mon_row    = w_open[mon_bank] ? r_row[mon_bank] : 15'd0;
  assign rd_data_en = r_rd_sr[0];
  assign wr_data_en = r_wr_sr[0];
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;

endmodule
